// File: rtl/pcie_ptm_tx_sniffer.sv
// PIPE TX tap: forwards symbols untouched and reports outgoing PTM Requests
// with the local time captured when their STP left the core.
module pcie_ptm_tx_sniffer #(
  parameter int TS_WIDTH = 64
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [15:0]         tx_data_in,
  input  logic [1:0]          tx_ctl_in,
  output logic [15:0]         tx_data_out,
  output logic [1:0]          tx_ctl_out,
  input  logic [TS_WIDTH-1:0] timestamp_in,
  output logic                ptm_req_valid_out,
  output logic [TS_WIDTH-1:0] ptm_req_ts_out,
  output logic [15:0]         ptm_req_id_out,
  output logic                ptm_req_lane_out,
  input  logic                ptm_req_ack_in,
  output logic [15:0]         ptm_req_count_out,
  output logic [15:0]         ptm_abort_count_out,
  output logic                ptm_overflow_out,
  input  logic                ptm_overflow_clr_in
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_END = 8'hFD;

  logic [1:0]          r_state;
  logic [4:0]          r_idx;
  logic [TS_WIDTH-1:0] r_cand_ts;
  logic                r_cand_lane;
  logic [15:0]         r_cand_id;

  logic [1:0]  w_state;
  logic [4:0]  w_idx;
  logic [15:0] w_id;
  logic        w_stp;
  logic        w_stp_lane;
  logic        w_good;
  logic        w_abort;
  logic [7:0]  w_b;
  logic        w_k;
  logic        w_hold;

  assign tx_data_out = tx_data_in;
  assign tx_ctl_out  = tx_ctl_in;

  // Lane 0 then lane 1; an END can only land at idx 22, so a good
  // request always sees the candidate as registered.
  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_id       = r_cand_id;
    w_stp      = 1'b0;
    w_stp_lane = r_cand_lane;
    w_good     = 1'b0;
    w_abort    = 1'b0;
    w_b        = 8'h00;
    w_k        = 1'b0;
    for (int l = 0; l < 2; l++) begin
      w_b = tx_data_in[8*l +: 8];
      w_k = tx_ctl_in[l];
      case (w_state)
        S_IDLE: begin
          if (w_k && w_b == K_STP) begin
            w_state    = S_HDR;
            w_idx      = 5'd0;
            w_stp      = 1'b1;
            w_stp_lane = (l == 1);
          end
        end
        S_HDR: begin
          if (w_k) begin
            if (w_b == K_STP) begin
              w_idx      = 5'd0;
              w_stp      = 1'b1;
              w_stp_lane = (l == 1);
            end else begin
              w_state = S_IDLE;
            end
          end else begin
            if (w_idx == 5'd2 && w_b != 8'h34)
              w_state = S_IDLE;
            if (w_idx == 5'd6)
              w_id[15:8] = w_b;
            if (w_idx == 5'd7)
              w_id[7:0] = w_b;
            if (w_idx == 5'd9)
              w_state = (w_b == 8'h52) ? S_TAIL : S_IDLE;
            w_idx = w_idx + 5'd1;
          end
        end
        S_TAIL: begin
          w_hold = (w_idx != 5'd22) && !w_k;
          if (w_hold) begin
            w_idx = w_idx + 5'd1;
          end else if (w_idx == 5'd22 && w_k && w_b == K_END) begin
            w_good  = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_abort = 1'b1;
            if (w_k && w_b == K_STP) begin
              w_state    = S_HDR;
              w_idx      = 5'd0;
              w_stp      = 1'b1;
              w_stp_lane = (l == 1);
            end else begin
              w_state = S_IDLE;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state             <= S_IDLE;
      r_idx               <= 5'd0;
      r_cand_ts           <= '0;
      r_cand_lane         <= 1'b0;
      r_cand_id           <= 16'h0;
      ptm_req_valid_out   <= 1'b0;
      ptm_req_ts_out      <= '0;
      ptm_req_id_out      <= 16'h0;
      ptm_req_lane_out    <= 1'b0;
      ptm_req_count_out   <= 16'h0;
      ptm_abort_count_out <= 16'h0;
      ptm_overflow_out    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_cand_id <= w_id;
      if (w_stp) begin
        r_cand_ts   <= timestamp_in;
        r_cand_lane <= w_stp_lane;
      end
      if (w_abort)
        ptm_abort_count_out <= ptm_abort_count_out + 16'd1;
      if (w_good) begin
        ptm_req_count_out <= ptm_req_count_out + 16'd1;
        if (!ptm_req_valid_out || ptm_req_ack_in) begin
          ptm_req_valid_out <= 1'b1;
          ptm_req_ts_out    <= r_cand_ts;
          ptm_req_id_out    <= r_cand_id;
          ptm_req_lane_out  <= r_cand_lane;
        end
      end else if (ptm_req_ack_in) begin
        ptm_req_valid_out <= 1'b0;
      end
      // Oldest request is kept; a lost one marks overflow.
      if (w_good && ptm_req_valid_out && !ptm_req_ack_in)
        ptm_overflow_out <= 1'b1;
      else if (ptm_overflow_clr_in)
        ptm_overflow_out <= 1'b0;
    end
  end

endmodule
